// File: rtl/vga_timing_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_if
//  Description : Control and timing-output bundle for vga_timing. The master
//                side is the timing generator and the slave side is the
//                consumer, which supplies the run enable.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_timing_if;
    logic       en;
    logic       pix_tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       blank;
    logic       line_done;
    logic       frame_done;

    modport master (
        input  en,
        output pix_tick, hcount, vcount, hsync, vsync,
               active, blank, line_done, frame_done
    );

    modport slave (
        output en,
        input  pix_tick, hcount, vcount, hsync, vsync,
               active, blank, line_done, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing
//  Description : VGA raster timing generator. It divides clk down to a pixel
//                strobe, keeps the column and line counters, and produces
//                registered sync and active flags aligned with the counts.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    vga_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The divider is 4 bits wide because CLK_DIV never exceeds 16.
    localparam logic [3:0]  c_DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0]  c_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  c_V_LAST   = 10'(V_TOTAL - 1);

    // Window bounds are 11 bits wide so that a sync pulse ending exactly at
    // 1024 still compares correctly.
    localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  r_div;
    logic [9:0]  r_hcount;
    logic [9:0]  r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_active;
    logic        r_blank;

    logic        w_tick;
    logic        w_h_last;
    logic        w_v_last;
    logic [9:0]  w_h_nxt;
    logic [9:0]  w_v_nxt;
    logic [10:0] w_h_nxt_x;
    logic [10:0] w_v_nxt_x;
    logic        w_hsync_nxt;
    logic        w_vsync_nxt;
    logic        w_active_nxt;

    assign w_tick   = bus.en & ~rst & (r_div == c_DIV_LAST);
    assign w_h_last = (r_hcount == c_H_LAST);
    assign w_v_last = (r_vcount == c_V_LAST);

    // Next raster position: advance on a pixel tick, otherwise hold.
    always_comb begin
        w_h_nxt = r_hcount;
        w_v_nxt = r_vcount;
        if (w_tick) begin
            if (w_h_last) begin
                w_h_nxt = 10'd0;
                w_v_nxt = w_v_last ? 10'd0 : r_vcount + 10'd1;
            end else begin
                w_h_nxt = r_hcount + 10'd1;
            end
        end
    end

    // Flags are decoded from the next position so that, once registered,
    // they line up with the counts on the same cycle.
    assign w_h_nxt_x    = {1'b0, w_h_nxt};
    assign w_v_nxt_x    = {1'b0, w_v_nxt};
    assign w_hsync_nxt  = ~((w_h_nxt_x >= c_HS_START) && (w_h_nxt_x < c_HS_END));
    assign w_vsync_nxt  = ~((w_v_nxt_x >= c_VS_START) && (w_v_nxt_x < c_VS_END));
    assign w_active_nxt = (w_h_nxt_x < c_H_ACT) && (w_v_nxt_x < c_V_ACT);

    // Timing state: divider, counters and registered flags; en=0 freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= 4'd0;
            r_hcount <= 10'd0;
            r_vcount <= 10'd0;
            r_hsync  <= 1'b1;
            r_vsync  <= 1'b1;
            r_active <= 1'b1;
            r_blank  <= 1'b0;
        end else if (bus.en) begin
            r_div    <= (r_div == c_DIV_LAST) ? 4'd0 : r_div + 4'd1;
            r_hcount <= w_h_nxt;
            r_vcount <= w_v_nxt;
            r_hsync  <= w_hsync_nxt;
            r_vsync  <= w_vsync_nxt;
            r_active <= w_active_nxt;
            r_blank  <= ~w_active_nxt;
        end
    end

    assign bus.pix_tick   = w_tick;
    assign bus.line_done  = w_tick & w_h_last;
    assign bus.frame_done = w_tick & w_h_last & w_v_last;
    assign bus.hcount     = r_hcount;
    assign bus.vcount     = r_vcount;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.active     = r_active;
    assign bus.blank      = r_blank;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vga_timing
//  Description : Directed self-checking bench for vga_timing. Three instances:
//                default geometry at CLK_DIV=4, default geometry at
//                CLK_DIV=1, and a miniature 15x10 raster at CLK_DIV=3 so a
//                whole frame fits in a short run.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst0;
    logic rst1;
    logic rst2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_timing_if u_if0 ();
    vga_timing_if u_if1 ();
    vga_timing_if u_if2 ();

    vga_timing #(.CLK_DIV(4)) u_dut0 (.clk(clk), .rst(rst0), .bus(u_if0));
    vga_timing #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(u_if1));
    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3)
    ) u_dut2 (.clk(clk), .rst(rst2), .bus(u_if2));

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fall_h, hs_cnt, hs_min, hs_max, ld_cnt, ld_h, found;
        int chg, seen, pcnt, first_ld, second_ld;
        int vs_cnt, vs_min, vs_max, act_bad, blank_bad, fd_cnt, fd_cyc, fd_ld;

        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        u_if0.en = 1'b1; u_if1.en = 1'b0; u_if2.en = 1'b0;
        repeat (3) step();

        // ---------------- reset state (en=1 held during reset) -------------
        check("rst_hcount", int'(u_if0.hcount), 0);
        check("rst_vcount", int'(u_if0.vcount), 0);
        check("rst_hsync",  int'(u_if0.hsync), 1);
        check("rst_vsync",  int'(u_if0.vsync), 1);
        check("rst_active", int'(u_if0.active), 1);
        check("rst_blank",  int'(u_if0.blank), 0);
        check("rst_tick",   int'(u_if0.pix_tick), 0);

        // ---------------- first ticks after reset, CLK_DIV=4 ---------------
        rst0 = 1'b0;
        step(); step();
        check("tick_e2", int'(u_if0.pix_tick), 0);
        step();
        check("tick_e3", int'(u_if0.pix_tick), 1);
        check("h_e3", int'(u_if0.hcount), 0);
        step();
        check("h_e4", int'(u_if0.hcount), 1);
        check("tick_e4", int'(u_if0.pix_tick), 0);
        step(); step(); step();
        check("tick_e7", int'(u_if0.pix_tick), 1);
        step();
        check("h_e8", int'(u_if0.hcount), 2);

        // ---------------- one full line ------------------------------------
        fall_h = -1; hs_cnt = 0; hs_min = 9999; hs_max = -1;
        ld_cnt = 0; ld_h = -1; found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            step();
            if (!u_if0.active && fall_h < 0) fall_h = int'(u_if0.hcount);
            if (!u_if0.hsync) begin
                hs_cnt++;
                if (int'(u_if0.hcount) < hs_min) hs_min = int'(u_if0.hcount);
                if (int'(u_if0.hcount) > hs_max) hs_max = int'(u_if0.hcount);
            end
            if (u_if0.line_done) begin
                ld_cnt++;
                ld_h  = int'(u_if0.hcount);
                found = 1;
            end
        end
        check("line_done_seen", found, 1);
        check("active_fall_h", fall_h, 640);
        check("hsync_low_clk", hs_cnt, 384);
        check("hsync_first_h", hs_min, 656);
        check("hsync_last_h",  hs_max, 751);
        check("line_done_h",   ld_h, 799);
        step();
        if (u_if0.line_done) ld_cnt++;
        check("wrap_hcount", int'(u_if0.hcount), 0);
        check("wrap_vcount", int'(u_if0.vcount), 1);
        check("wrap_active", int'(u_if0.active), 1);
        check("line_done_once", ld_cnt, 1);

        // ---------------- freeze at hcount=300 -----------------------------
        found = 0;
        for (int i = 0; i < 2000 && found == 0; i++) begin
            step();
            if (u_if0.hcount == 10'd300) found = 1;
        end
        check("reach_300", found, 1);
        u_if0.en = 1'b0;
        #1;
        check("frz_tick_now", int'(u_if0.pix_tick), 0);
        chg = 0; seen = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (u_if0.hcount != 10'd300 || u_if0.vcount != 10'd1 ||
                u_if0.hsync != 1'b1 || u_if0.vsync != 1'b1 ||
                u_if0.active != 1'b1 || u_if0.blank != 1'b0) chg++;
            if (u_if0.pix_tick || u_if0.line_done || u_if0.frame_done) seen++;
        end
        check("frz_changes", chg, 0);
        check("frz_strobes", seen, 0);
        u_if0.en = 1'b1;
        step(); step(); step();
        check("resume_h_e3", int'(u_if0.hcount), 300);
        check("resume_tick", int'(u_if0.pix_tick), 1);
        step();
        check("resume_h_e4", int'(u_if0.hcount), 301);

        // ---------------- CLK_DIV=1 ----------------------------------------
        u_if1.en = 1'b1;
        #1;
        check("div1_rst_tick", int'(u_if1.pix_tick), 0);
        rst1 = 1'b0;
        #1;
        check("div1_tick0", int'(u_if1.pix_tick), 1);
        pcnt = 0; ld_cnt = 0; first_ld = -1; second_ld = -1;
        for (int i = 1; i <= 1600; i++) begin
            step();
            if (u_if1.pix_tick) pcnt++;
            if (u_if1.line_done) begin
                ld_cnt++;
                if (first_ld < 0) first_ld = i;
                else if (second_ld < 0) second_ld = i;
            end
        end
        check("div1_tick_cnt", pcnt, 1600);
        check("div1_ld_cnt", ld_cnt, 2);
        check("div1_ld_first", first_ld, 799);
        check("div1_ld_period", second_ld - first_ld, 800);

        // ---------------- full frame on the 15x10 raster, CLK_DIV=3 --------
        u_if2.en = 1'b1;
        rst2 = 1'b0;
        vs_cnt = 0; vs_min = 9999; vs_max = -1; act_bad = 0; blank_bad = 0;
        fd_cnt = 0; fd_cyc = -1; fd_ld = 0; found = 0;
        for (int i = 1; i <= 1000 && found == 0; i++) begin
            step();
            if (!u_if2.vsync) begin
                vs_cnt++;
                if (int'(u_if2.vcount) < vs_min) vs_min = int'(u_if2.vcount);
                if (int'(u_if2.vcount) > vs_max) vs_max = int'(u_if2.vcount);
            end
            if (u_if2.active && u_if2.vcount >= 10'd6) act_bad++;
            if (u_if2.blank == u_if2.active) blank_bad++;
            if (u_if2.frame_done) begin
                fd_cnt++;
                fd_cyc = i;
                fd_ld  = int'(u_if2.line_done);
                found  = 1;
            end
        end
        check("frame_done_seen", found, 1);
        check("frame_done_cyc", fd_cyc, 449);
        check("frame_done_ld", fd_ld, 1);
        check("vsync_low_clk", vs_cnt, 90);
        check("vsync_first_v", vs_min, 7);
        check("vsync_last_v", vs_max, 8);
        check("active_in_vblank", act_bad, 0);
        check("blank_not_inverse", blank_bad, 0);
        step();
        if (u_if2.frame_done) fd_cnt++;
        check("frame_wrap_h", int'(u_if2.hcount), 0);
        check("frame_wrap_v", int'(u_if2.vcount), 0);
        check("frame_wrap_active", int'(u_if2.active), 1);
        check("frame_done_once", fd_cnt, 1);

        // ---------------- reset pulse inside both sync pulses --------------
        found = 0;
        for (int i = 0; i < 1000 && found == 0; i++) begin
            step();
            if (u_if2.hcount == 10'd12 && u_if2.vcount == 10'd8) found = 1;
        end
        check("reach_12_8", found, 1);
        check("pre_rst_hsync", int'(u_if2.hsync), 0);
        check("pre_rst_vsync", int'(u_if2.vsync), 0);
        check("pre_rst_blank", int'(u_if2.blank), 1);
        rst2 = 1'b1;
        step();
        check("mid_rst_h", int'(u_if2.hcount), 0);
        check("mid_rst_v", int'(u_if2.vcount), 0);
        check("mid_rst_hsync", int'(u_if2.hsync), 1);
        check("mid_rst_vsync", int'(u_if2.vsync), 1);
        check("mid_rst_active", int'(u_if2.active), 1);
        check("mid_rst_blank", int'(u_if2.blank), 0);
        check("mid_rst_tick", int'(u_if2.pix_tick), 0);
        rst2 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
